// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the I/D cache fill sequencer.
package cache_ctrl_pkg;

  localparam int   WORDS_PER_BLK = 8;
  localparam int   WORD_IDX_W    = 3;
  localparam int   BLK_OFF_W     = 4;
  localparam logic SEL_ICACHE    = 1'b0;
  localparam logic SEL_DCACHE    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fillState_t;

endpackage

// File: rtl/blk_word_cnt.sv
// Word counter within a block fill; holds at the last index until cleared.
module blk_word_cnt
  import cache_ctrl_pkg::*;
#(
  parameter int W = WORD_IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = &count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined main memory between I-cache fills, D-cache fills and
// D-side write-through stores.
//
//   state | meaning
//   IDLE  | arbitrate: D miss, then store (same-cycle), then I miss
//   FILL  | issue one block word read per cycle
//   DRAIN | all reads issued, collecting the remaining returns
//   DONE  | pulse the done strobe of the granted side, clear counters
module cache_fill_arbiter #(
  parameter int WORDS_PER_BLK = 8,
  parameter int ADDR_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_miss_req,
  input  logic [ADDR_W-1:0]                i_miss_addr,
  input  logic                             d_miss_req,
  input  logic [ADDR_W-1:0]                d_miss_addr,
  input  logic                             d_wr_req,
  input  logic [ADDR_W-1:0]                d_wr_addr,
  input  logic [15:0]                      d_wr_data,
  output logic                             d_wr_ack,
  output logic                             mem_en,
  output logic                             mem_wr,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [15:0]                      mem_wdata,
  input  logic [15:0]                      mem_rdata,
  input  logic                             mem_rvalid,
  output logic                             fill_we,
  output logic                             fill_sel,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
  output logic [15:0]                      fill_data,
  output logic                             i_fill_done,
  output logic                             d_fill_done,
  output logic                             busy
);
  import cache_ctrl_pkg::*;

  localparam int IdxW = $clog2(WORDS_PER_BLK);
  localparam int OffW = IdxW + 1;

  fillState_t              state;
  logic                    grant;
  logic [ADDR_W-1:OffW]    blkTag;
  logic [IdxW-1:0]         issCnt;
  logic [IdxW-1:0]         rcvCnt;
  logic                    issLast;
  logic                    rcvLast;
  logic                    issInc;
  logic                    rcvInc;
  logic                    cntClr;
  logic                    wrGrant;
  logic                    unusedOffBits;

  // Byte offset within the block is irrelevant to a whole-block fill.
  assign unusedOffBits = ^{i_miss_addr[OffW-1:0], d_miss_addr[OffW-1:0]};

  assign wrGrant = (state == IDLE) && d_wr_req && !d_miss_req;
  assign issInc  = (state == FILL);
  assign rcvInc  = mem_rvalid && ((state == FILL) || (state == DRAIN));
  assign cntClr  = (state == DONE);

  blk_word_cnt #(.W(IdxW)) u_issCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (issInc),
    .clr   (cntClr),
    .count (issCnt),
    .last  (issLast)
  );

  blk_word_cnt #(.W(IdxW)) u_rcvCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rcvInc),
    .clr   (cntClr),
    .count (rcvCnt),
    .last  (rcvLast)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= SEL_ICACHE;
      blkTag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_miss_req) begin
            grant  <= SEL_DCACHE;
            blkTag <= d_miss_addr[ADDR_W-1:OffW];
            state  <= FILL;
          end else if (!d_wr_req && i_miss_req) begin
            grant  <= SEL_ICACHE;
            blkTag <= i_miss_addr[ADDR_W-1:OffW];
            state  <= FILL;
          end
        end
        FILL: begin
          if (rcvInc && rcvLast) begin
            state <= DONE;
          end else if (issLast) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rcvInc && rcvLast) begin
            state <= DONE;
          end
        end
        // Requests still high here are stale; they are only seen again in IDLE.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (wrGrant) begin
      mem_addr  = d_wr_addr;
      mem_wdata = d_wr_data;
    end else if (state == FILL) begin
      mem_addr = {blkTag, issCnt, 1'b0};
    end
  end

  assign mem_en      = wrGrant || (state == FILL);
  assign mem_wr      = wrGrant;
  assign d_wr_ack    = wrGrant;
  assign fill_we     = rcvInc;
  assign fill_sel    = grant;
  assign fill_word   = rcvCnt;
  assign fill_data   = mem_rdata;
  assign i_fill_done = (state == DONE) && (grant == SEL_ICACHE);
  assign d_fill_done = (state == DONE) && (grant == SEL_DCACHE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: memory with fixed 4-cycle read latency,
// a cycle-count reference model, directed timing pins and random traffic.
module tb_cache_fill_arbiter;

  localparam int LOGN = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        fill_we, fill_sel, i_fill_done, d_fill_done, busy;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.WORDS_PER_BLK(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory: every read returns exactly 4 cycles after its issue cycle.
  typedef struct { int due; logic [15:0] addr; } rd_t;
  rd_t pend[$];

  always @(posedge clk) begin
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memWord(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
  end

  logic        logEn[LOGN], logWr[LOGN], logAck[LOGN], logWe[LOGN];
  logic        logSel[LOGN], logID[LOGN], logDD[LOGN], logBusy[LOGN];
  logic [15:0] logAddr[LOGN], logWdata[LOGN];
  logic [2:0]  logWord[LOGN];

  logic iDoneLast, dDoneLast, ackLast;
  bit   modelOn = 1'b0;

  // Reference model: k counts cycles since the grant (0 = idle, 13 = done pulse).
  int          k = 0;
  logic        mGrant = 1'b0;
  logic [15:0] mBlk = 16'h0;

  always @(negedge clk) begin
    logic        eEn, eWr, eAck, eWe, eID, eDD, eBusy, nGrant;
    logic [15:0] eAddr, eWdata, nBlk, base;
    int          nk;

    if (mem_en === 1'b1 && mem_wr === 1'b0) pend.push_back('{due: cyc + 4, addr: mem_addr});
    iDoneLast = i_fill_done;
    dDoneLast = d_fill_done;
    ackLast   = d_wr_ack;
    if (cyc < LOGN) begin
      logEn[cyc] = mem_en;   logWr[cyc] = mem_wr;     logAck[cyc] = d_wr_ack;
      logWe[cyc] = fill_we;  logSel[cyc] = fill_sel;  logID[cyc] = i_fill_done;
      logDD[cyc] = d_fill_done; logBusy[cyc] = busy;  logAddr[cyc] = mem_addr;
      logWdata[cyc] = mem_wdata; logWord[cyc] = fill_word;
    end

    if (modelOn) begin
      eEn = 0; eWr = 0; eAck = 0; eWe = 0; eID = 0; eDD = 0;
      eBusy = (k != 0); eAddr = 0; eWdata = 0;
      nk = k; nGrant = mGrant; nBlk = mBlk;
      base = mBlk & 16'hFFF0;
      if (k == 0) begin
        if (d_miss_req) begin
          nGrant = 1'b1; nBlk = d_miss_addr; nk = 1;
        end else if (d_wr_req) begin
          eEn = 1; eWr = 1; eAck = 1; eAddr = d_wr_addr; eWdata = d_wr_data;
        end else if (i_miss_req) begin
          nGrant = 1'b0; nBlk = i_miss_addr; nk = 1;
        end
      end else begin
        if (k <= 8) begin
          eEn = 1; eAddr = base + 16'(2 * (k - 1));
        end
        eWe = mem_rvalid && (k <= 12);
        eID = (k == 13) && !mGrant;
        eDD = (k == 13) && mGrant;
        nk  = (k == 13) ? 0 : k + 1;
      end
      if (rst) begin
        nk = 0; nGrant = 1'b0; nBlk = 16'h0;
      end

      chk("busy", busy, eBusy);
      chk("mem_en", mem_en, eEn);
      if (eEn) begin
        chk("mem_wr", mem_wr, eWr);
        chk("mem_addr", mem_addr, eAddr);
        if (eWr) chk("mem_wdata", mem_wdata, eWdata);
      end
      chk("d_wr_ack", d_wr_ack, eAck);
      chk("fill_we", fill_we, eWe);
      chk("fill_sel", fill_sel, mGrant);
      chk("fill_data_pass", fill_data, mem_rdata);
      chk("i_fill_done", i_fill_done, eID);
      chk("d_fill_done", d_fill_done, eDD);
      if (eWe) begin
        chk("fill_word", fill_word, k - 5);
        chk("fill_data_word", fill_data, memWord(base + 16'(2 * (k - 5))));
      end
      k = nk; mGrant = nGrant; mBlk = nBlk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (iDoneLast === 1'b1) i_miss_req = 1'b0;
    if (dDoneLast === 1'b1) d_miss_req = 1'b0;
    if (ackLast === 1'b1)   d_wr_req   = 1'b0;
  endtask

  int t1, t2, t3, t4, t5, t6, t7, s;

  initial begin
    rst = 1'b1;
    i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
    i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;

    tick();
    modelOn = 1'b1;
    @(negedge clk);
    chk("reset_flags", {24'h0, mem_en, mem_wr, d_wr_ack, fill_we, fill_sel,
                        i_fill_done, d_fill_done, busy}, 32'h0);
    chk("reset_mem_addr", mem_addr, 16'h0);
    chk("reset_mem_wdata", mem_wdata, 16'h0);
    chk("reset_fill_word", fill_word, 3'd0);
    tick();
    rst = 1'b0;
    tick();

    // I miss alone
    i_miss_req = 1; i_miss_addr = 16'h0046; t1 = cyc;
    repeat (16) tick();
    chk("t1_iss0_en", logEn[t1+1], 1'b1);
    chk("t1_iss0_addr", logAddr[t1+1], 16'h0040);
    chk("t1_iss7_addr", logAddr[t1+8], 16'h004E);
    chk("t1_iss_stop", logEn[t1+9], 1'b0);
    chk("t1_we_before", logWe[t1+4], 1'b0);
    chk("t1_we_first", logWe[t1+5], 1'b1);
    chk("t1_word_first", logWord[t1+5], 3'd0);
    chk("t1_word_last", logWord[t1+12], 3'd7);
    chk("t1_sel", logSel[t1+5], 1'b0);
    chk("t1_idone_early", logID[t1+12], 1'b0);
    chk("t1_idone", logID[t1+13], 1'b1);
    chk("t1_idle", logBusy[t1+14], 1'b0);

    // D and I miss together: D first
    d_miss_req = 1; d_miss_addr = 16'h1000; i_miss_req = 1; i_miss_addr = 16'h2000; t2 = cyc;
    repeat (30) tick();
    chk("t2_d_addr", logAddr[t2+1], 16'h1000);
    chk("t2_d_sel", logSel[t2+5], 1'b1);
    chk("t2_ddone", logDD[t2+13], 1'b1);
    chk("t2_no_idone", logID[t2+13], 1'b0);
    chk("t2_regrant_no_en", logEn[t2+14], 1'b0);
    chk("t2_i_en", logEn[t2+15], 1'b1);
    chk("t2_i_addr", logAddr[t2+15], 16'h2000);
    chk("t2_i_sel", logSel[t2+19], 1'b0);
    chk("t2_idone", logID[t2+27], 1'b1);

    // Store in IDLE, then the same store held during a fill
    d_wr_req = 1; d_wr_addr = 16'h3002; d_wr_data = 16'hBEEF; t3 = cyc;
    tick();
    chk("t3_ack", logAck[t3], 1'b1);
    chk("t3_en_wr", {logEn[t3], logWr[t3]}, 2'b11);
    chk("t3_addr", logAddr[t3], 16'h3002);
    chk("t3_wdata", logWdata[t3], 16'hBEEF);
    i_miss_req = 1; i_miss_addr = 16'h0500; t4 = cyc;
    tick();
    d_wr_req = 1; d_wr_addr = 16'h3002; d_wr_data = 16'hBEEF;
    repeat (16) tick();
    s = 0;
    for (int c = t4 + 1; c <= t4 + 13; c++) s += int'(logAck[c]);
    chk("t4_no_ack_busy", s, 0);
    chk("t4_ack_idle", logAck[t4+14], 1'b1);
    chk("t4_ack_addr", logAddr[t4+14], 16'h3002);

    // Store and I miss together: store first
    d_wr_req = 1; d_wr_addr = 16'h3004; d_wr_data = 16'h1234;
    i_miss_req = 1; i_miss_addr = 16'h0600; t5 = cyc;
    repeat (18) tick();
    chk("t5_ack", logAck[t5], 1'b1);
    chk("t5_still_idle", logBusy[t5+1], 1'b0);
    chk("t5_no_read", logEn[t5+1], 1'b0);
    chk("t5_first_read", {logEn[t5+2], logWr[t5+2]}, 2'b10);
    chk("t5_first_addr", logAddr[t5+2], 16'h0600);
    chk("t5_idone", logID[t5+14], 1'b1);

    // Reset in the middle of a fill
    i_miss_req = 1; i_miss_addr = 16'h0700; t6 = cyc;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; i_miss_req = 1'b0;
    repeat (6) tick();
    chk("t6_busy_at_rst", logBusy[t6+7], 1'b1);
    chk("t6_idle_after", logBusy[t6+8], 1'b0);
    s = 0;
    for (int c = t6 + 8; c <= t6 + 13; c++) s += int'(logWe[c]);
    chk("t6_no_we", s, 0);
    s = 0;
    for (int c = t6 + 7; c <= t6 + 13; c++) s += int'(logID[c]) + int'(logDD[c]);
    chk("t6_no_done", s, 0);
    i_miss_req = 1; i_miss_addr = 16'h0800; t7 = cyc;
    repeat (16) tick();
    chk("t7_addr", logAddr[t7+1], 16'h0800);
    chk("t7_idone", logID[t7+13], 1'b1);

    // Random traffic
    repeat (3000) begin
      tick();
      if (!i_miss_req && iDoneLast !== 1'b1 && $urandom_range(0, 7) == 0) begin
        i_miss_req = 1; i_miss_addr = 16'($urandom);
      end
      if (!d_miss_req && dDoneLast !== 1'b1 && $urandom_range(0, 9) == 0) begin
        d_miss_req = 1; d_miss_addr = 16'($urandom);
      end
      if (!d_wr_req && ackLast !== 1'b1 && $urandom_range(0, 5) == 0) begin
        d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      end
    end
    repeat (40) tick();
    i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Sequences the single shared multi-cycle main memory between the CPU's instruction-cache miss path (IF stage) and data-cache miss/write path (MEM stage). It arbitrates among pending requests and issues 8 pipelined word reads per block fill. Returned words are steered into the granted cache with a word index, and a one-cycle done pulse releases the stalled stage. Data-side write-through stores are passed to memory as single-cycle writes when no fill is in progress.

## Interface
- `WORDS_PER_BLK`, default 8: 16-bit words per cache block; power of two.
- `ADDR_W`, default 16: byte-address width.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_miss_req` in 1: I-cache miss; held until `i_fill_done`.
- `i_miss_addr` in 16: I-side miss byte address; offset bits ignored.
- `d_miss_req` in 1: D-cache miss; held until `d_fill_done`.
- `d_miss_addr` in 16: D-side miss byte address.
- `d_wr_req` in 1: write-through store request.
- `d_wr_addr` in 16: store byte address.
- `d_wr_data` in 16: store data.
- `d_wr_ack` out 1: store accepted this cycle (combinational).
- `mem_en` out 1: memory access this cycle.
- `mem_wr` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: memory byte address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data.
- `mem_rvalid` in 1: `mem_rdata` valid; fixed 4 cycles after its read issue.
- `fill_we` out 1: write `fill_data` into the cache selected by `fill_sel`.
- `fill_sel` out 1: 0 = I-cache, 1 = D-cache (registered grant).
- `fill_word` out 3: word index within the block.
- `fill_data` out 16: equals `mem_rdata`.
- `i_fill_done` out 1: one-cycle pulse at I fill completion.
- `d_fill_done` out 1: one-cycle pulse at D fill completion.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE grant priority (decided combinationally, registered into `grant`/`blk_addr`):
  - `d_miss_req` is highest: `fill_sel`=1, go to FILL.
  - Else `d_wr_req`: in the same cycle drive `mem_en`=1, `mem_wr`=1, `mem_addr`=`d_wr_addr`, `mem_wdata`=`d_wr_data`, `d_wr_ack`=1; stay in IDLE.
  - Else `i_miss_req`: `fill_sel`=0, go to FILL.
- FILL: each cycle drive `mem_en`=1, `mem_wr`=0, `mem_addr`={`blk_addr`[15:4], `iss_cnt`, 1'b0}, then increment `iss_cnt`. After issuing word 7, go to DRAIN.
- FILL/DRAIN: on `mem_rvalid`, drive `fill_we`=1 and `fill_word`=`rcv_cnt`, then increment `rcv_cnt`. Receiving word 7 goes to DONE.
- DONE: pulse `i_fill_done` or `d_fill_done` per grant, clear counters, return to IDLE. Requests are ignored in DONE so a stale, still-high request is not re-granted.
- `mem_rvalid` in IDLE or DONE is ignored (no `fill_we`).
- `d_wr_req` during FILL, DRAIN or DONE is not acked; the requester holds it.
- Counters are 3 bits and wrap 7→0 only via the DONE clear.

## Timing
- Reset values: state=IDLE, counters=0, grant=0. All outputs are 0 except `fill_data` (follows `mem_rdata`).
- Request sampled in IDLE at cycle t:
  - Word 0 issued at t+1, word 7 at t+8.
  - Data at t+5 through t+12.
  - Done pulse at t+13; IDLE at t+14; next grant decision at t+14.
- Fill penalty: 14 cycles from request to re-arbitration.
- Store: acked in the same cycle it is presented in IDLE; zero extra latency.
- Reset mid-fill: next cycle is IDLE. No done pulse is issued, and in-flight `mem_rvalid` words are dropped. Requesters re-request.

## Structure
- Package `cache_ctrl_pkg`:
  - state enum (IDLE/FILL/DRAIN/DONE)
  - `WORDS_PER_BLK`, `WORD_IDX_W`=3
  - `BLK_OFF_W`=4
  - `SEL_ICACHE`=0, `SEL_DCACHE`=1
- Sub-module `blk_word_cnt`: 3-bit counter with inc, clr, sync reset, and `last` flag. It is instantiated twice, for issue and receive.

## Test plan
- I miss only, `i_miss_addr`=0x0046: reads issued to 0x0040..0x004E at t+1..t+8. `fill_we` with `fill_sel`=0, words 0..7 at t+5..t+12. `i_fill_done` pulses at t+13.
- `d_miss_req` and `i_miss_req` asserted together, addrs 0x1000/0x2000: D fill from 0x1000 first with `d_fill_done` at t+13. I fill then starts at t+15 and `i_fill_done` pulses at t+27.
- `d_wr_req` to 0x3002 with data 0xBEEF in IDLE: same-cycle `mem_wr`=1, addr 0x3002, `d_wr_ack`=1. The same store presented during FILL gets no ack until DONE→IDLE.
- `d_wr_req` together with `i_miss_req`: store acked first. The I fill starts the following cycle and its first read issues one cycle later.
- `rst` asserted at t+7 during FILL: IDLE at t+8. No `fill_we` for the remaining `mem_rvalid`, and no done pulse. A new request is granted normally.
